// File: rtl/hazard_flush_ctrl.sv
// Load-use / branch / memory-freeze hazard control for the pipeline buffers and PC.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_flush_ctrl #(
    parameter int REG_W        = 4,
    parameter int LOAD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IFID_RS,
    input  logic [REG_W-1:0] IFID_RT,
    input  logic             IFID_UsesRT,
    input  logic [REG_W-1:0] IDEX_RT,
    input  logic             IDEX_MemRead,
    input  logic             BranchTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IDEX_WRITE,
    output logic             EXMEM_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_FLUSH,
    output logic             PC_SRC
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stall_count,
    output logic [15:0]      flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    state_t     eff;
    logic [2:0] bcnt_q, bcnt_d;
    logic       lu_hit;
    logic       mem_stall;
    logic       br_resp;

    assign lu_hit = IDEX_MemRead &&
                    ((IDEX_RT == IFID_RS) ||
                     (IFID_UsesRT && (IDEX_RT == IFID_RT)));
    assign mem_stall = MemReq && !MemReady;

    // While frozen, behave as the state we will return to
    assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IDEX_WRITE  = 1'b1;
        EXMEM_WRITE = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_FLUSH  = 1'b0;
        EXMEM_FLUSH = 1'b0;
        PC_SRC      = 1'b0;
        state_d     = RUN;
        ret_d       = ret_q;
        bcnt_d      = bcnt_q;
        br_resp     = 1'b0;
        if (rst) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
            ret_d       = RUN;
            bcnt_d      = 3'd0;
        end else if (mem_stall) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            state_d     = MEM_WAIT;
            ret_d       = eff;
        end else if (BranchTaken) begin
            PC_SRC      = 1'b1;
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            EXMEM_FLUSH = 1'b1;
            bcnt_d      = 3'd0;
            br_resp     = 1'b1;
        end else if (eff == LU_STALL) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_FLUSH = 1'b1;
            bcnt_d     = bcnt_q - 3'd1;
            state_d    = (bcnt_q == 3'd1) ? RUN : LU_STALL;
        end else if (lu_hit) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_FLUSH = 1'b1;
            if (LOAD_LATENCY > 1) begin
                state_d = LU_STALL;
                bcnt_d  = 3'(LOAD_LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            bcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bcnt_q  <= bcnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (!PC_WRITE && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (br_resp && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`else
    logic unused_br;
    assign unused_br = br_resp;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench: two instances (LOAD_LATENCY 1 and 3) share stimulus;
// expected control vectors go through a scoreboard queue.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs, rt, xrt;
    logic       usesrt, memrd, br, mreq, mrdy;

    logic pw1, fw1, dw1, ew1, ff1, df1, ef1, ps1;
    logic pw3, fw3, dw3, ew3, ff3, df3, ef3, ps3;
`ifdef HAZARD_STATS_EN
    logic [15:0] sc1, fc1, sc3, fc3;
`endif

    int errors = 0;
    int checks = 0;
    int stepn  = 0;
    logic [15:0] sbq[$];

    localparam logic [7:0] DEF = 8'b1111_0000;
    localparam logic [7:0] RST = 8'b0000_1110;
    localparam logic [7:0] LU  = 8'b0011_0100;
    localparam logic [7:0] BR  = 8'b1111_1111;
    localparam logic [7:0] MEM = 8'b0000_0000;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.REG_W(4), .LOAD_LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .IFID_RS(rs), .IFID_RT(rt), .IFID_UsesRT(usesrt),
        .IDEX_RT(xrt), .IDEX_MemRead(memrd),
        .BranchTaken(br), .MemReq(mreq), .MemReady(mrdy),
        .PC_WRITE(pw1), .IFID_WRITE(fw1), .IDEX_WRITE(dw1),
        .EXMEM_WRITE(ew1), .IFID_FLUSH(ff1), .IDEX_FLUSH(df1),
        .EXMEM_FLUSH(ef1), .PC_SRC(ps1)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    hazard_flush_ctrl #(.REG_W(4), .LOAD_LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .IFID_RS(rs), .IFID_RT(rt), .IFID_UsesRT(usesrt),
        .IDEX_RT(xrt), .IDEX_MemRead(memrd),
        .BranchTaken(br), .MemReq(mreq), .MemReady(mrdy),
        .PC_WRITE(pw3), .IFID_WRITE(fw3), .IDEX_WRITE(dw3),
        .EXMEM_WRITE(ew3), .IFID_FLUSH(ff3), .IDEX_FLUSH(df3),
        .EXMEM_FLUSH(ef3), .PC_SRC(ps3)
`ifdef HAZARD_STATS_EN
        , .stall_count(sc3), .flush_count(fc3)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock step: drive inputs, queue expectations, compare mid-cycle
    task automatic step(input logic r, input logic [3:0] a_rs,
                        input logic [3:0] a_rt, input logic u,
                        input logic [3:0] a_xrt, input logic m,
                        input logic b, input logic q, input logic y,
                        input logic [7:0] e1, input logic [7:0] e3);
        logic [15:0] e;
        rst = r; rs = a_rs; rt = a_rt; usesrt = u;
        xrt = a_xrt; memrd = m; br = b; mreq = q; mrdy = y;
        sbq.push_back({e1, e3});
        stepn++;
        @(negedge clk);
        e = sbq.pop_front();
        chk8($sformatf("s%0d_L1", stepn),
             {pw1, fw1, dw1, ew1, ff1, df1, ef1, ps1}, e[15:8]);
        chk8($sformatf("s%0d_L3", stepn),
             {pw3, fw3, dw3, ew3, ff3, df3, ef3, ps3}, e[7:0]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with branch asserted
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, RST, RST);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, RST, RST);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // load-use on RS
        step(0, 3, 0, 0, 3, 1, 0, 0, 0, LU,  LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // RT match ignored unless used
        step(0, 0, 3, 0, 3, 1, 0, 0, 0, DEF, DEF);
        step(0, 0, 3, 1, 3, 1, 0, 0, 0, LU,  LU);
        // branch in second stall cycle
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, BR,  BR);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // register 0 hazards stall too
        step(0, 0, 5, 0, 0, 1, 0, 0, 0, LU,  LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // memory freeze swallows branch until ready
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 0, 1, 1, 0, MEM, MEM);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, BR,  BR);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // freeze inside a load stall resumes the stall
        step(0, 7, 0, 0, 7, 1, 0, 0, 0, LU,  LU);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, MEM, MEM);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // branch with hazard: branch only
        step(0, 2, 0, 0, 2, 1, 1, 0, 0, BR,  BR);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        // reset mid-stall and mid-freeze
        step(0, 9, 0, 0, 9, 1, 0, 0, 0, LU,  LU);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, RST);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, MEM, MEM);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, RST, RST);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
`ifdef HAZARD_STATS_EN
        step(0, 4, 0, 0, 4, 1, 0, 0, 0, LU,  LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, LU);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, BR,  BR);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, BR,  BR);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, DEF);
        chk16("stall_L3", sc3, 16'd3);
        chk16("flush_L3", fc3, 16'd2);
        chk16("stall_L1", sc1, 16'd1);
        rst = 0; mreq = 1; mrdy = 0; br = 0; memrd = 0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk16("stall_sat", sc3, 16'hFFFF);
        chk16("flush_hold", fc3, 16'd2);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
